uart_rx: RTL and testbench

UART receiver at the front of the image-upload path. It samples the asynchronous serial input `rx` and deserializes 8N1 frames into bytes. Each valid byte is presented with a `rx_data_ready` strobe to the framebuffer writer, which packs bytes into 32-bit framebuffer words. Framing errors are flagged and the byte is dropped, so the writer never sees a corrupt byte.

---
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-FF input synchronizer, glitch-rejecting start detect and stop-bit check.
// Latency: byte and ready strobe appear 1 clock after the stop-bit sample; the pin-to-rxs sync adds 2 clocks.
// Backpressure: none; rx_data_ready is a fixed RDY_CYCLES strobe and rx_data holds until the next good frame.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int RDY_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       frame_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam int RW           = $clog2(RDY_CYCLES);

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
  localparam logic [RW-1:0] RDY_LAST  = RW'(RDY_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic          rx_meta;
  logic          rxs;
  logic          rx_prev;
  logic          start_fall;
  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [RW-1:0] rdy_cnt;

  // Every entry into IDLE follows a cycle with rxs=1, so the first low
  // sample seen in IDLE is always this falling edge.
  assign start_fall = rx_prev & ~rxs;

  // Two-flop synchronizer for the asynchronous line plus one edge register; idle level is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rx_prev <= rxs;
    end
  end

  // Receive FSM with registered outputs; the ready strobe counts down alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT_IDLE;
      timer         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rdy_cnt       <= '0;
      rx_data       <= '0;
      rx_data_ready <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_error <= 1'b0;

      if (rx_data_ready) begin
        if (rdy_cnt == '0) rx_data_ready <= 1'b0;
        else               rdy_cnt       <= rdy_cnt - 1'b1;
      end

      case (state)
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end

        IDLE: begin
          if (start_fall) begin
            timer <= '0;
            busy  <= 1'b1;
            state <= START;
          end
        end

        START: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (rxs) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (timer == BIT_LAST) begin
            timer   <= '0;
            shift   <= {rxs, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            busy  <= 1'b0;
            if (rxs) begin
              rx_data       <= shift;
              rx_data_ready <= 1'b1;
              rdy_cnt       <= RDY_LAST;
              state         <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ns
// tb_uart_rx: directed bench for uart_rx at 1 MHz clock, 100 kbaud (10 clocks per bit, half bit 5).
// All line transitions happen at even ns; clock rises at 5 mod 10, so rx never changes at an active edge.
// A negedge monitor captures each strobe's byte, strobe length, frame_error width and busy edges.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int RDY      = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       frame_error;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .RDY_CYCLES(RDY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_data_ready(rx_data_ready),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] rx_q[$];
  int  fe_cnt        = 0;
  int  hi_len        = 0;
  int  fe_len        = 0;
  int  busy_rise_cnt = 0;
  time rdy_rise_t    = 0;
  time busy_rise_t   = 0;
  time busy_fall_t   = 0;
  logic rdy_d  = 1'b0;
  logic fe_d   = 1'b0;
  logic busy_d = 1'b0;

  always @(negedge clk) begin
    if (rx_data_ready) hi_len++;
    if (rx_data_ready && !rdy_d) begin
      rx_q.push_back(rx_data);
      rdy_rise_t = $time;
    end
    if (!rx_data_ready && rdy_d) begin
      check("strobe_len", hi_len, RDY);
      hi_len = 0;
    end
    if (frame_error) fe_len++;
    if (frame_error && !fe_d) fe_cnt++;
    if (!frame_error && fe_d) begin
      check("fe_width", fe_len, 1);
      fe_len = 0;
    end
    if (busy && !busy_d) begin
      busy_rise_cnt++;
      busy_rise_t = $time;
    end
    if (!busy && busy_d) busy_fall_t = $time;
    rdy_d  = rx_data_ready;
    fe_d   = frame_error;
    busy_d = busy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic at(input time t);
    if ($time < t) #(t - $time);
  endtask

  // Drives one frame; the line is left at the stop-bit level.
  task automatic send(input logic [7:0] b, input int bit_ns, input logic stop_bit);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  logic [7:0] exp_skew[128];

  initial begin
    // Reset values
    at(50);
    check("rst_data", rx_data, 8'h00);
    check("rst_rdy", rx_data_ready, 1'b0);
    check("rst_fe", frame_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    at(100);
    reset = 1'b0;

    // Reset mid-frame (bit 3 of 0xA5), released during bit 6 while the line is low
    at(400);
    fork
      send(8'hA5, 100, 1'b1);
      begin
        at(848);
        check("midrst_busy_before", busy, 1'b1);
        at(850);
        reset = 1'b1;
        #2;
        check("midrst_data", rx_data, 8'h00);
        check("midrst_rdy", rx_data_ready, 1'b0);
        check("midrst_fe", frame_error, 1'b0);
        check("midrst_busy", busy, 1'b0);
        at(1150);
        reset = 1'b0;
      end
    join
    at(2500);
    check("midrst_no_strobe", rx_q.size(), 0);
    check("midrst_no_fe", fe_cnt, 0);

    // Single byte 0x5A: start edge at 3000, first capture edge 3005, T ends at 3025,
    // stop sample edge 3975 -> strobe/data visible at negedge 3980
    at(3000);
    send(8'h5A, 100, 1'b1);
    at(4200);
    check("single_count", rx_q.size(), 1);
    check("single_data", rx_q[0], 8'h5A);
    check("single_rdy_rise_t", 32'(rdy_rise_t), 3980);
    check("single_busy_rise_t", 32'(busy_rise_t), 3030);
    check("single_busy_fall_t", 32'(busy_fall_t), 3980);
    check("single_hold_data", rx_data, 8'h5A);
    check("single_rdy_low", rx_data_ready, 1'b0);

    // Back-to-back 0x00, 0xFF, 0x81
    at(5000);
    send(8'h00, 100, 1'b1);
    send(8'hFF, 100, 1'b1);
    send(8'h81, 100, 1'b1);
    at(8300);
    check("b2b_count", rx_q.size(), 4);
    check("b2b_byte0", rx_q[1], 8'h00);
    check("b2b_byte1", rx_q[2], 8'hFF);
    check("b2b_byte2", rx_q[3], 8'h81);

    // Glitch: 3 cycles low
    begin
      int br;
      br = busy_rise_cnt;
      at(9000);
      rx = 1'b0;
      #30;
      rx = 1'b1;
      at(9200);
      check("glitch_busy_pulse", busy_rise_cnt, br + 1);
      check("glitch_busy_low", busy, 1'b0);
      check("glitch_no_strobe", rx_q.size(), 4);
    end
    at(9500);
    send(8'h3C, 100, 1'b1);
    at(10700);
    check("post_glitch_count", rx_q.size(), 5);
    check("post_glitch_data", rx_q[4], 8'h3C);

    // Framing error on 0xC3, line held low 30 cycles, then 0x11
    at(11000);
    send(8'hC3, 100, 1'b0);
    check("ferr_count", fe_cnt, 1);
    check("ferr_data_kept", rx_data, 8'h3C);
    check("ferr_no_strobe", rx_q.size(), 5);
    #300;
    rx = 1'b1;
    at(12500);
    send(8'h11, 100, 1'b1);
    at(13700);
    check("post_ferr_count", rx_q.size(), 6);
    check("post_ferr_data", rx_q[5], 8'h11);

    // Baud skew: 64 bytes at 10.4 clocks/bit, 64 at 9.6 clocks/bit
    at(14000);
    for (int i = 0; i < 128; i++) begin
      exp_skew[i] = 8'($urandom_range(0, 255));
      send(exp_skew[i], (i < 64) ? 104 : 96, 1'b1);
      #20;
    end
    #500;
    check("skew_count", rx_q.size(), 6 + 128);
    for (int i = 0; i < 128; i++) begin
      check((i < 64) ? "skew_slow_byte" : "skew_fast_byte", rx_q[6 + i], exp_skew[i]);
    end
    check("skew_no_fe", fe_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
